// File: rtl/dmem_ctrl.sv
// Word-organised data memory controller: byte/half/word loads and stores, configurable read latency.
// Define DMEM_MISALIGN_EXC_EN to flag misaligned accesses (suppress them) instead of force-aligning them.
module dmem_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        stall,
    output logic        misalign
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state, state_nxt;
    logic [1:0]         cnt;
    logic [31:0]        pend;
    logic [31:0]        mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0]  idx;
    logic [1:0]         off;
    logic [3:0]         be;
    logic [31:0]        wrep, word, sh, ld_data;
    logic               mis, accept, st, ld, wr_ok;

    assign idx       = req_addr[ADDR_W+1:2];
    assign req_ready = (state == IDLE) || rsp_valid;
    assign stall     = req_valid && !req_ready;
    assign accept    = req_valid && req_ready;
    assign st        = accept && req_we;
    assign ld        = accept && !req_we;
    assign mis       = (req_size == 2'd1 && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00);

    // Lane offset with misaligned halves/words snapped down to their natural boundary.
    always_comb begin
        off  = 2'b00;
        be   = 4'hF;
        wrep = req_wdata;
        case (req_size)
            2'd0: begin
                off  = req_addr[1:0];
                be   = 4'b0001 << req_addr[1:0];
                wrep = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                off  = {req_addr[1], 1'b0};
                be   = 4'b0011 << {req_addr[1], 1'b0};
                wrep = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign word = mem[idx];
    assign sh   = word >> {off, 3'b000};

    always_comb begin
        case (req_size)
            2'd0:    ld_data = req_unsigned ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'd1:    ld_data = req_unsigned ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: ld_data = word;
        endcase
`ifdef DMEM_MISALIGN_EXC_EN
        if (mis) ld_data = 32'd0;
`endif
    end

`ifdef DMEM_MISALIGN_EXC_EN
    assign wr_ok = !mis;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) misalign <= 1'b0;
        else      misalign <= accept && mis;
    end
`else
    assign wr_ok    = 1'b1;
    assign misalign = 1'b0;
`endif

    logic unused;
    assign unused = ^{req_addr[31:ADDR_W+2], mis};

    // Array has no reset so it can map onto a RAM.
    always_ff @(posedge clk) begin
        if (st && wr_ok) begin
            for (int k = 0; k < 4; k++)
                if (be[k]) mem[idx][8*k +: 8] <= wrep[8*k +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (ld) state_nxt = BUSY;
            BUSY: if (rsp_valid) state_nxt = ld ? BUSY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read data is captured at the accepting edge and released when the counter expires.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= 2'd0;
            pend      <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
        end else begin
            rsp_valid <= 1'b0;
            if (ld) begin
                pend <= ld_data;
                if (LATENCY == 1) begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= ld_data;
                    cnt       <= 2'd0;
                end else begin
                    cnt <= 2'(LATENCY - 1);
                end
            end else if (cnt != 2'd0) begin
                cnt <= cnt - 2'd1;
                if (cnt == 2'd1) begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= pend;
                end
            end
        end
    end

endmodule
